// File: rtl/noc_tx_packetizer.sv
// NoC transmit packetizer: packet request plus payload stream become head/body/tail flits under credit flow control.
// Optional macro NOC_TX_SELF_DROP_EN: packets addressed to this node are drained locally instead of sent.
module noc_tx_packetizer #(
    parameter logic [7:0] ROUTER_ADDR = 8'h00,
    parameter int         DATA_W      = 32,
    parameter int         BUF_DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_dest_i,
    input  logic [3:0]        req_len_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              flit_valid_o,
    output logic [DATA_W+1:0] flit_o,
    input  logic              credit_i
);
    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;
    localparam logic [3:0] DEPTH       = 4'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_DRAIN} state_t;

    state_t            r_state;
    logic [7:0]        r_dest;
    logic [3:0]        r_len;
    logic [3:0]        r_remaining;
    logic [3:0]        r_credits;
    logic              r_flit_valid;
    logic [DATA_W+1:0] r_flit;

    logic              w_has_credit;
    logic              w_req_hs;
    logic              w_data_hs;
    logic              w_send;
    logic              w_self;
    logic [DATA_W-1:0] w_header;

    assign w_has_credit = (r_credits != 4'd0);
    assign req_ready_o  = (r_state == S_IDLE);

`ifdef NOC_TX_SELF_DROP_EN
    // Draining a self-addressed packet never touches the router, so credits do not gate it.
    assign data_ready_o = ((r_state == S_BODY) && w_has_credit) || (r_state == S_DRAIN);
    assign w_self       = (req_dest_i == ROUTER_ADDR);
`else
    assign data_ready_o = (r_state == S_BODY) && w_has_credit;
    assign w_self       = 1'b0;
`endif

    assign w_req_hs  = req_valid_i & req_ready_o;
    assign w_data_hs = data_valid_i & data_ready_o;
    assign w_send    = ((r_state == S_HEAD) && w_has_credit) || ((r_state == S_BODY) && w_data_hs);

    always_comb begin
        w_header        = '0;
        w_header[7:0]   = r_dest;
        w_header[15:8]  = ROUTER_ADDR;
        w_header[19:16] = r_len;
    end

    // Packet sequencing; flit outputs are registered here so they leave the block glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_dest       <= 8'h00;
            r_len        <= 4'd0;
            r_remaining  <= 4'd0;
            r_flit_valid <= 1'b0;
            r_flit       <= '0;
        end else begin
            r_flit_valid <= w_send;
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_dest      <= req_dest_i;
                        r_len       <= req_len_i;
                        r_remaining <= req_len_i;
                        if (!w_self) begin
                            r_state <= S_HEAD;
                        end else if (req_len_i != 4'd0) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_HEAD: begin
                    if (w_has_credit) begin
                        r_flit  <= {(r_len == 4'd0) ? TYPE_SINGLE : TYPE_HEAD, w_header};
                        r_state <= (r_len == 4'd0) ? S_IDLE : S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_data_hs) begin
                        r_flit      <= {(r_remaining == 4'd1) ? TYPE_TAIL : TYPE_BODY, data_i};
                        r_remaining <= r_remaining - 4'd1;
                        if (r_remaining == 4'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_data_hs) begin
                        r_remaining <= r_remaining - 4'd1;
                        if (r_remaining == 4'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A returned credit and a sent flit in the same cycle cancel; returns beyond the buffer depth are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credits <= DEPTH;
        end else begin
            case ({w_send, credit_i})
                2'b10:   r_credits <= r_credits - 4'd1;
                2'b01:   if (r_credits < DEPTH) r_credits <= r_credits + 4'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign flit_valid_o = r_flit_valid;
    assign flit_o       = r_flit;

endmodule

// File: tb/tb_noc_tx_packetizer.sv
// Bench for noc_tx_packetizer: packet-level reference model checked every cycle, plus literal flit checks.
// Build with NOC_TX_SELF_DROP_EN defined to exercise the self-addressed drain path.
module tb_noc_tx_packetizer;
    localparam int         DATA_W      = 32;
    localparam int         FW          = DATA_W + 2;
    localparam int         BUF_DEPTH   = 4;
    localparam logic [7:0] ROUTER_ADDR = 8'h12;

    logic              clk_i        = 1'b0;
    logic              rst_ni       = 1'b0;
    logic              req_valid_i  = 1'b0;
    logic [7:0]        req_dest_i   = 8'h00;
    logic [3:0]        req_len_i    = 4'd0;
    logic              data_valid_i = 1'b0;
    logic [DATA_W-1:0] data_i       = '0;
    logic              credit_i     = 1'b0;
    logic              req_ready_o;
    logic              data_ready_o;
    logic              flit_valid_o;
    logic [FW-1:0]     flit_o;

    int            total    = 0;
    int            bad      = 0;
    int            cycle    = 0;
    bit            checkOn  = 1'b0;
    bit            abortPkt = 1'b0;
    logic [FW-1:0] seenFlit[$];
    int            seenCycle[$];

    bit            mBusy        = 1'b0;
    bit            mHeadPending = 1'b0;
    bit            mDrop        = 1'b0;
    bit            mSend        = 1'b0;
    int            mBodyLeft    = 0;
    int            mCredits     = BUF_DEPTH;
    logic [7:0]    mDest        = 8'h00;
    logic [3:0]    mLen         = 4'd0;
    bit            expValid     = 1'b0;
    logic [FW-1:0] expFlit      = '0;
    logic [FW-1:0] mNext        = '0;

    noc_tx_packetizer #(
        .ROUTER_ADDR(ROUTER_ADDR),
        .DATA_W     (DATA_W),
        .BUF_DEPTH  (BUF_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_dest_i  (req_dest_i),
        .req_len_i   (req_len_i),
        .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .data_i      (data_i),
        .flit_valid_o(flit_valid_o),
        .flit_o      (flit_o),
        .credit_i    (credit_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [FW-1:0] flitAt(input int i);
        if (i < seenFlit.size()) return seenFlit[i];
        return 'x;
    endfunction

    function automatic int cycleAt(input int i);
        if (i < seenCycle.size()) return seenCycle[i];
        return -1000;
    endfunction

    // Packet-level reference: what the link must carry given requests, words offered and credits returned.
    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            mBusy = 0; mHeadPending = 0; mDrop = 0; mBodyLeft = 0;
            mCredits = BUF_DEPTH; expValid = 0; expFlit = '0;
        end else begin
            mSend = 0;
            if (!mBusy) begin
                if (req_valid_i) begin
                    mDest = req_dest_i; mLen = req_len_i; mBodyLeft = req_len_i;
                    mDrop = 0; mBusy = 1; mHeadPending = 1;
`ifdef NOC_TX_SELF_DROP_EN
                    if (req_dest_i == ROUTER_ADDR) begin
                        mDrop = 1; mHeadPending = 0; mBusy = (req_len_i != 0);
                    end
`endif
                end
            end else if (mHeadPending) begin
                if (mCredits > 0) begin
                    mSend = 1;
                    mNext = {(mLen == 0) ? 2'b11 : 2'b01, DATA_W'({mLen, ROUTER_ADDR, mDest})};
                    mHeadPending = 0;
                    if (mLen == 0) mBusy = 0;
                end
            end else if (data_valid_i && (mDrop || mCredits > 0)) begin
                if (!mDrop) begin
                    mSend = 1;
                    mNext = {(mBodyLeft == 1) ? 2'b10 : 2'b00, data_i};
                end
                mBodyLeft--;
                if (mBodyLeft == 0) begin mBusy = 0; mDrop = 0; end
            end
            if (mSend && !credit_i) mCredits--;
            else if (!mSend && credit_i && mCredits < BUF_DEPTH) mCredits++;
            expValid = mSend;
            if (mSend) expFlit = mNext;
        end
    end

    initial forever begin
        @(negedge clk_i);
        cycle++;
        if (rst_ni && checkOn) begin
            checkOutput("req_ready", {63'd0, req_ready_o}, {63'd0, !mBusy});
            checkOutput("data_ready", {63'd0, data_ready_o},
                        {63'd0, mBusy && !mHeadPending && (mDrop || mCredits > 0)});
            checkOutput("flit_valid", {63'd0, flit_valid_o}, {63'd0, expValid});
            if (expValid) checkOutput("flit", 64'(flit_o), 64'(expFlit));
        end
        if (rst_ni && flit_valid_o) begin
            seenFlit.push_back(flit_o);
            seenCycle.push_back(cycle);
        end
    end

    // Offers one request and its len payload words; words may be offered before the body phase starts.
    task automatic applyStimulus(input logic [7:0] dest, input logic [3:0] len, input int gapPct,
                                 input bit randCred, input bit fixedData, input logic [DATA_W-1:0] base);
        bit                reqPending = 1;
        int                words      = 0;
        int                budget     = 400;
        logic [DATA_W-1:0] cur;
        cur = fixedData ? base : DATA_W'($urandom);
        while ((reqPending || words < int'(len)) && budget > 0 && !abortPkt) begin
            @(negedge clk_i);
            req_valid_i  = reqPending;
            req_dest_i   = dest;
            req_len_i    = len;
            data_valid_i = (words < int'(len)) && ($urandom_range(99) >= gapPct);
            data_i       = cur;
            if (randCred) credit_i = ($urandom_range(2) == 0);
            #1;
            if (reqPending && req_ready_o) reqPending = 0;
            if (data_valid_i && data_ready_o) begin
                words++;
                cur = fixedData ? base + DATA_W'(words) : DATA_W'($urandom);
            end
            budget--;
        end
        @(negedge clk_i);
        req_valid_i  = 0;
        data_valid_i = 0;
        if (randCred) credit_i = 0;
        if (budget == 0 && !abortPkt) checkOutput("packet_budget", 64'(words), 64'(len));
    endtask

    task automatic pulseCredit();
        @(negedge clk_i); credit_i = 1;
        @(negedge clk_i); credit_i = 0;
    endtask

    initial begin
        int n;
        int c;
        logic [7:0] d;

        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rst_flit_valid", {63'd0, flit_valid_o}, 64'd0);
        checkOutput("rst_flit", 64'(flit_o), 64'd0);
        checkOutput("rst_data_ready", {63'd0, data_ready_o}, 64'd0);
        rst_ni = 1;
        @(negedge clk_i);
        #1;
        checkOutput("idle_req_ready", {63'd0, req_ready_o}, 64'd1);
        checkOutput("idle_credits", 64'(dut.r_credits), 64'd4);
        checkOn = 1;

        $display("[TB] streamed packet dest 33 len 2");
        n = seenFlit.size();
        applyStimulus(8'h33, 4'd2, 0, 0, 1, 32'hA);
        repeat (3) @(negedge clk_i);
        checkOutput("pkt1_head", 64'(flitAt(n)), 64'({2'b01, 32'h0002_1233}));
        checkOutput("pkt1_body", 64'(flitAt(n + 1)), 64'({2'b00, 32'h0000_000A}));
        checkOutput("pkt1_tail", 64'(flitAt(n + 2)), 64'({2'b10, 32'h0000_000B}));
        checkOutput("pkt1_b2b", 64'(cycleAt(n + 2) - cycleAt(n)), 64'd2);
        checkOutput("pkt1_credits", 64'(dut.r_credits), 64'd1);

        $display("[TB] zero-length packet dest 21");
        n = seenFlit.size();
        applyStimulus(8'h21, 4'd0, 0, 0, 0, '0);
        for (int i = 0; i < 10 && seenFlit.size() == n; i++) begin
            @(negedge clk_i); #1;
        end
        checkOutput("single_flit", 64'(flitAt(n)), 64'({2'b11, 32'h0000_1221}));
        checkOutput("single_next_req_ready", {63'd0, req_ready_o}, 64'd1);

        $display("[TB] credit stall with len 4");
        n = seenFlit.size();
        fork
            applyStimulus(8'h45, 4'd4, 0, 0, 1, 32'h100);
            begin
                repeat (8) @(negedge clk_i);
                checkOutput("stall_no_flit", 64'(seenFlit.size()), 64'(n));
                pulseCredit();
                repeat (6) @(negedge clk_i);
                #1;
                checkOutput("one_credit_one_flit", 64'(seenFlit.size()), 64'(n + 1));
                checkOutput("stall_data_ready", {63'd0, data_ready_o}, 64'd0);
                for (int i = 0; i < 4; i++) begin
                    pulseCredit();
                    @(negedge clk_i);
                end
            end
        join
        repeat (3) @(negedge clk_i);
        checkOutput("stall_head", 64'(flitAt(n)), 64'({2'b01, 32'h0004_1245}));
        checkOutput("stall_tail", 64'(flitAt(n + 4)), 64'({2'b10, 32'h0000_0103}));

        for (int i = 0; i < 6; i++) pulseCredit();
        #1;
        checkOutput("credit_saturate", 64'(dut.r_credits), 64'd4);

        $display("[TB] credit return coincident with header");
        n = seenFlit.size();
        @(negedge clk_i);
        req_valid_i = 1; req_dest_i = 8'h56; req_len_i = 4'd0;
        @(negedge clk_i);
        req_valid_i = 0; credit_i = 1;
        @(negedge clk_i);
        credit_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("coincident_flit", 64'(flitAt(n)), 64'({2'b11, 32'h0000_1256}));
        checkOutput("coincident_credits", 64'(dut.r_credits), 64'd4);

        $display("[TB] reset mid-body");
        n = seenFlit.size();
        fork
            applyStimulus(8'h78, 4'd8, 0, 0, 1, 32'h200);
            begin
                for (int i = 0; i < 40 && seenFlit.size() < n + 3; i++) begin
                    @(negedge clk_i); #1;
                end
                checkOutput("pre_reset_flits", 64'(seenFlit.size()), 64'(n + 3));
                #1;
                rst_ni   = 0;
                abortPkt = 1;
                #1;
                checkOutput("async_flit_valid", {63'd0, flit_valid_o}, 64'd0);
                checkOutput("async_flit", 64'(flit_o), 64'd0);
                checkOutput("async_data_ready", {63'd0, data_ready_o}, 64'd0);
                checkOutput("async_credits", 64'(dut.r_credits), 64'd4);
                repeat (2) @(negedge clk_i);
                #2;
                rst_ni = 1;
            end
        join
        abortPkt = 0;
        @(negedge clk_i);
        #1;
        checkOutput("post_reset_req_ready", {63'd0, req_ready_o}, 64'd1);
        n = seenFlit.size();
        applyStimulus(8'h9A, 4'd2, 0, 0, 1, 32'h300);
        repeat (3) @(negedge clk_i);
        checkOutput("post_reset_head", 64'(flitAt(n)), 64'({2'b01, 32'h0002_129A}));
        checkOutput("post_reset_tail", 64'(flitAt(n + 2)), 64'({2'b10, 32'h0000_0301}));

`ifdef NOC_TX_SELF_DROP_EN
        $display("[TB] self-addressed drop");
        n = seenFlit.size();
        c = int'(dut.r_credits);
        applyStimulus(ROUTER_ADDR, 4'd3, 0, 0, 1, 32'h400);
        repeat (3) @(negedge clk_i);
        checkOutput("drop_no_flits", 64'(seenFlit.size()), 64'(n));
        checkOutput("drop_credits", 64'(dut.r_credits), 64'(c));
`else
        c = 0;
`endif

        $display("[TB] randomized packets");
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(3))
                0:       d = ROUTER_ADDR;
                1:       d = 8'h33;
                default: d = 8'($urandom);
            endcase
            applyStimulus(d, 4'($urandom_range(15)), 30, 1, 0, '0);
        end
        credit_i = 0;
        repeat (20) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_tx_packetizer.md
# noc_tx_packetizer

Network-interface transmitter that sits between a local core and the local input port of its mesh router. It accepts a packet request (destination YX address plus a body length) and a stream of payload words. It emits a header flit carrying the YX address consumed by the router's YX routing logic, followed by body flits, the last one marked tail. Output is credit-flow-controlled against the router's input buffer.

## Interface
- `ROUTER_ADDR`, default 8'h00: this node's YX address; upper nibble Y, lower nibble X.
- `DATA_W`, default 32: payload width. Must be ≥ 20.
- `BUF_DEPTH`, default 4: router input buffer depth, which is the initial credit count (1..15).
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: packet request valid.
- `req_ready_o` out 1: request accepted when both valid and ready are high.
- `req_dest_i` in 8: destination YX address, same format as `ROUTER_ADDR`.
- `req_len_i` in 4: number of body flits (0..15).
- `data_valid_i` in 1: payload word valid.
- `data_ready_o` out 1: payload word consumed when both valid and ready are high.
- `data_i` in DATA_W: payload word.
- `flit_valid_o` out 1: flit present this cycle. There is no ready signal; flow control is by credits.
- `flit_o` out DATA_W+2: {type[1:0], payload}. Types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail.
- `credit_i` in 1: one-cycle pulse; the router freed one buffer slot.

## Operation
- Header payload:
  - [7:0] = dest
  - [15:8] = ROUTER_ADDR
  - [19:16] = len
  - upper bits = 0
- Body payload is `data_i` unchanged.
- FSM states: IDLE, HEAD, BODY.
  - IDLE: `req_ready_o` = 1. On handshake, latch dest and len, set `remaining` = len, go to HEAD.
  - HEAD: when credits > 0, register the header flit and go to BODY.
    - Type is 2'b01 if len > 0.
    - Type is 2'b11 if len = 0; in that case go to IDLE instead.
  - BODY: `data_ready_o` = (credits > 0). On a data handshake, register a body flit and decrement `remaining`.
    - When `remaining` was 1, the flit type is 2'b10 and the FSM returns to IDLE.
    - Otherwise the type is 2'b00.
- `req_ready_o` is 0 outside IDLE. `data_ready_o` is 0 outside BODY.
- Credit counter: 4 bits, reset to BUF_DEPTH.
  - Flit sent: decrement.
  - `credit_i` pulse: increment.
  - Both in the same cycle: unchanged.
  - A `credit_i` pulse that would exceed BUF_DEPTH is ignored (saturate).
- No flit is ever emitted with credits = 0. The FSM holds state, `flit_valid_o` is 0, and `data_ready_o` is 0.
- Payload words arriving while not in BODY are not consumed.

## Timing
- Request handshake at edge N: the header flit is valid in cycle N+1 when credits > 0, otherwise in the first cycle after a credit is available.
- A body flit appears in the cycle after its data handshake. With credits ample and data streaming, flits are back-to-back, one per cycle.
- Minimum packet occupancy is 1 + len cycles plus 1 IDLE cycle. A new request is accepted in the cycle after the tail/head+tail flit is registered.
- `flit_valid_o` and `flit_o` are registered. `flit_valid_o` is high for exactly one cycle per flit.
- Reset values, including reset asserted mid-packet (which abandons the packet with no tail):
  - state = IDLE
  - credits = BUF_DEPTH
  - `flit_valid_o` = 0
  - `flit_o` = 0
  - `req_ready_o` = 1 after release
  - `data_ready_o` = 0

## Configuration
- `NOC_TX_SELF_DROP_EN` defined: a request with `req_dest_i` == ROUTER_ADDR is accepted and dropped.
  - No flits are emitted and no credits are consumed.
  - The FSM enters BODY-drain, asserting `data_ready_o` = 1 regardless of credits. It discards len words, then returns to IDLE.
  - With len = 0 it stays in IDLE.
- Undefined: self-addressed packets are transmitted like any other. The router delivers them back to the local port.

## Test plan
- Reset with BUF_DEPTH=4, req dest 8'h33, len 2, data 32'hA, 32'hB streamed:
  - flits 01/{…,len 2, src 00, dest 33}, 00/A, 10/B on consecutive cycles.
  - credits end at 1.
- len 0, dest 8'h21: single flit type 2'b11 with payload[7:0]=8'h21; next request accepted the following cycle.
- BUF_DEPTH=2, len 4, no `credit_i`:
  - exactly 2 flits sent, then `data_ready_o` = 0 and the stall holds.
  - a `credit_i` pulse yields exactly one more flit.
- `credit_i` coincident with a flit send: credit count unchanged. Extra pulses at BUF_DEPTH saturate.
- Assert `rst_ni` low mid-BODY: outputs go 0 asynchronously. After release the FSM is in IDLE, credits = BUF_DEPTH, and a new packet is sent correctly.
- With `NOC_TX_SELF_DROP_EN`, dest = ROUTER_ADDR = 8'h12, len 3: 3 data words consumed, `flit_valid_o` never asserted, credits unchanged.
